pie_encoder: RTL and testbench

Reader-to-tag line encoder that sits directly downstream of the reader control FSM. It accepts the command bit stream (query, ACK, queryrep, NAK) one bit per handshake. It emits the EPC Gen2 pulse-interval-encoded (PIE) modulation envelope: delimiter, data-0, RTcal, optional TRcal, then data symbols. It returns to continuous wave (CW) between frames.

---
 rtl/pie_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_pie_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pie_encoder.sv
// pie_encoder: EPC Gen2 reader-to-tag PIE line encoder.
// Takes command bits one per valid/ready handshake. Emits the modulation
// envelope: delimiter, data-0, RTcal, optional TRcal, then the data symbols.
// The envelope sits at CW (tx_env=1) between frames.
// Optional feature: define PIE_PREAMBLE_EN to honour in_pre and emit TRcal.
// Without it, every frame uses frame-sync.

module pie_encoder #(
   parameter int TARI_CYCLES  = 8,
   parameter int PW_CYCLES    = 4,
   parameter int DATA1_CYCLES = 16,
   parameter int DELIM_CYCLES = 5,
   parameter int TRCAL_CYCLES = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic in_dat,
   input  logic in_vld,
   input  logic in_last,
   input  logic in_pre,
   output logic in_rdy,
   output logic tx_env,
   output logic tx_busy,
   output logic tx_done,
   output logic err_underrun
);

   localparam int CW = $clog2(TRCAL_CYCLES + 1);
   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [CW-1:0] LEN_DELIM = CW'(DELIM_CYCLES);
   localparam logic [CW-1:0] LEN_TARI  = CW'(TARI_CYCLES);
   localparam logic [CW-1:0] LEN_DATA1 = CW'(DATA1_CYCLES);
   localparam logic [CW-1:0] LEN_RTCAL = CW'(TARI_CYCLES + DATA1_CYCLES);
   localparam logic [CW-1:0] LEN_PW    = CW'(PW_CYCLES);
`ifdef PIE_PREAMBLE_EN
   localparam logic [CW-1:0] LEN_TRCAL = CW'(TRCAL_CYCLES);
`endif

   typedef enum logic [2:0] {
      IDLE,
      DELIM,
      DATA0,
      RTCAL,
`ifdef PIE_PREAMBLE_EN
      TRCAL,
`endif
      DATA
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] len, len_n;
   logic          cur_last, cur_last_n;
   logic          hold_dat, hold_last, hold_full;
   logic          last_accepted;
   logic          xfer, consume;
   logic          env_n, done_n, err_n;

`ifdef PIE_PREAMBLE_EN
   logic          pre_q;
`else
   logic          unused_pre;
   assign unused_pre = in_pre;
`endif

   assign in_rdy = !hold_full && !last_accepted;
   assign xfer   = in_vld && in_rdy;

   // Next-state, symbol counter/length and the envelope value for the next cycle
   always_comb begin
      state_n    = state;
      cnt_n      = cnt + ONE;
      len_n      = len;
      cur_last_n = cur_last;
      consume    = 1'b0;
      done_n     = 1'b0;
      err_n      = 1'b0;
      env_n      = 1'b1;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (xfer) state_n = DELIM;
         end
         DELIM: begin
            if (cnt == LEN_DELIM - ONE) begin
               state_n = DATA0;
               cnt_n   = '0;
               len_n   = LEN_TARI;
            end
         end
         DATA0: begin
            if (cnt == len - ONE) begin
               state_n = RTCAL;
               cnt_n   = '0;
               len_n   = LEN_RTCAL;
            end
         end
         RTCAL: begin
            if (cnt == len - ONE) begin
               cnt_n = '0;
`ifdef PIE_PREAMBLE_EN
               if (pre_q) begin
                  state_n = TRCAL;
                  len_n   = LEN_TRCAL;
               end else begin
                  state_n = DATA;
               end
`else
               state_n = DATA;
`endif
            end
         end
`ifdef PIE_PREAMBLE_EN
         TRCAL: begin
            if (cnt == len - ONE) begin
               state_n = DATA;
               cnt_n   = '0;
            end
         end
`endif
         DATA: begin
            if (cnt == '0) begin
               consume    = 1'b1;
               len_n      = hold_dat ? LEN_DATA1 : LEN_TARI;
               cur_last_n = hold_last;
            end else if (cnt == len - ONE) begin
               cnt_n = '0;
               if (cur_last) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else if (hold_full || xfer) begin
                  // A bit arriving on the final cycle still counts; dropping
                  // it would strand a full hold register in IDLE.
                  state_n = DATA;
               end else begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      case (state_n)
         IDLE:    env_n = 1'b1;
         DELIM:   env_n = 1'b0;
         default: env_n = (cnt_n < len_n - LEN_PW);
      endcase
   end

   // State, counter and current-symbol bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         len      <= LEN_TARI;
         cur_last <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         len      <= len_n;
         cur_last <= cur_last_n;
      end
   end

`ifdef PIE_PREAMBLE_EN
   // Latch the preamble/frame-sync choice with the first bit of a frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     pre_q <= 1'b0;
      else if (state == IDLE && xfer) pre_q <= in_pre;
   end
`endif

   // One-entry hold register; a new bit wins over a same-cycle consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_dat  <= 1'b0;
         hold_last <= 1'b0;
         hold_full <= 1'b0;
      end else if (xfer) begin
         hold_dat  <= in_dat;
         hold_last <= in_last;
         hold_full <= 1'b1;
      end else if (consume) begin
         hold_full <= 1'b0;
      end
   end

   // Stop accepting after the final bit until the frame returns to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     last_accepted <= 1'b0;
      else if (state_n == IDLE)    last_accepted <= 1'b0;
      else if (xfer && in_last)    last_accepted <= 1'b1;
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_env       <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done      <= 1'b0;
         err_underrun <= 1'b0;
      end else begin
         tx_env       <= env_n;
         tx_busy      <= (state_n != IDLE);
         tx_done      <= done_n;
         err_underrun <= err_n;
      end
   end

endmodule

// File: tb/tb_pie_encoder.sv
// tb_pie_encoder: directed self-checking bench for pie_encoder (default parameters).
// Honours PIE_PREAMBLE_EN the same way the design does.

module tb_pie_encoder;

   localparam int TARI  = 8;
   localparam int PW    = 4;
   localparam int D1    = 16;
   localparam int DELIM = 5;
   localparam int TRCAL = 40;

   logic clk, rst;
   logic in_dat, in_vld, in_last, in_pre;
   logic in_rdy, tx_env, tx_busy, tx_done, err_underrun;

   int checkCount = 0;
   int failCount  = 0;
   bit expEnv[$];

   pie_encoder dut (
      .clk(clk),
      .rst(rst),
      .in_dat(in_dat),
      .in_vld(in_vld),
      .in_last(in_last),
      .in_pre(in_pre),
      .in_rdy(in_rdy),
      .tx_env(tx_env),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .err_underrun(err_underrun)
   );

   // Free-running clock, posedge active
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a stuck run still terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Append one symbol of length L: high for L-PW cycles, low for PW
   task automatic buildSym(input int L);
      for (int i = 0; i < L; i++) expEnv.push_back(i < L - PW);
   endtask

   task automatic idleCycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput(tag, {tx_env, tx_busy, tx_done, err_underrun, in_rdy}, 5'b10001);
      end
   endtask

   task automatic driveBit(input logic [15:0] bits, input int idx, input int nbits, input bit lastFlag);
      if (idx < nbits) begin
         in_vld  = 1'b1;
         in_dat  = bits[idx];
         in_last = lastFlag && (idx == nbits - 1);
      end else begin
         in_vld  = 1'b0;
         in_dat  = 1'b0;
         in_last = 1'b0;
      end
   endtask

   // Sends bits[0..nbits-1] with in_vld high whenever a bit is pending and checks
   // the envelope cycle by cycle. lastFlag=0 leaves the frame open (underrun).
   // abortAt>0 asserts reset mid-frame at that cycle after the transfer.
   task automatic applyStimulus(input string name, input logic [15:0] bits, input int nbits,
                                input bit lastFlag, input bit pre, input int abortAt);
      int idx, xfers;
      bit xfer, xferPrev, lastSent, newLast;
      expEnv.delete();
      for (int i = 0; i < DELIM; i++) expEnv.push_back(1'b0);
      buildSym(TARI);
      buildSym(TARI + D1);
`ifdef PIE_PREAMBLE_EN
      if (pre) buildSym(TRCAL);
`endif
      for (int i = 0; i < nbits; i++) buildSym(bits[i] ? D1 : TARI);

      idx = 0; xfers = 0; lastSent = 1'b0;
      in_pre = pre;
      driveBit(bits, idx, nbits, lastFlag);
      checkOutput({name, ":rdy_start"}, in_rdy, 1);
      xfer    = in_vld && in_rdy;
      newLast = xfer && in_last;
      @(posedge clk); #1;
      if (xfer) begin idx++; xfers++; end
      driveBit(bits, idx, nbits, lastFlag);
      lastSent = newLast;
      xferPrev = xfer;

      for (int k = 0; k < expEnv.size(); k++) begin
         @(negedge clk);
         checkOutput({name, ":env_busy"}, {tx_env, tx_busy, tx_done, err_underrun},
                     {expEnv[k], 1'b1, 1'b0, 1'b0});
         if (xferPrev)      checkOutput({name, ":rdy_after_xfer"}, in_rdy, 0);
         else if (lastSent) checkOutput({name, ":rdy_after_last"}, in_rdy, 0);
         if (abortAt == k + 1) begin
            rst    = 1'b1;
            in_vld = 1'b0;
            #1;
            checkOutput({name, ":env_async_reset"}, tx_env, 1);
            checkOutput({name, ":reset_outputs"}, {tx_env, tx_busy, tx_done, err_underrun, in_rdy}, 5'b10001);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         xfer    = in_vld && in_rdy;
         newLast = xfer && in_last;
         @(posedge clk); #1;
         if (xfer) begin idx++; xfers++; end
         driveBit(bits, idx, nbits, lastFlag);
         lastSent = lastSent || newLast;
         xferPrev = xfer;
      end

      @(negedge clk);
      checkOutput({name, ":end_pulse"}, {tx_env, tx_busy, tx_done, err_underrun, in_rdy},
                  {1'b1, 1'b0, lastFlag, !lastFlag, 1'b1});
      checkOutput({name, ":xfer_count"}, xfers, nbits);
      in_vld = 1'b0;
   endtask

   // Directed sequence
   initial begin
      rst = 1'b1; in_vld = 1'b0; in_dat = 1'b0; in_last = 1'b0; in_pre = 1'b0;
      #2;
      checkOutput("reset_state", {tx_env, tx_busy, tx_done, err_underrun, in_rdy}, 5'b10001);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idleCycles("idle_after_reset", 2);

      // bits 1,0,1 frame-sync: 77 cycles
      applyStimulus("fsync_101", 16'b101, 3, 1'b1, 1'b0, 0);
      idleCycles("idle_fsync", 2);

      // single bit 0 with preamble: 85 cycles with TRcal, 45 without
      applyStimulus("pre_0", 16'b0, 1, 1'b1, 1'b1, 0);
      idleCycles("idle_pre", 2);

      // bit 1 not last, then nothing: underrun after 53 cycles
      applyStimulus("underrun_1", 16'b1, 1, 1'b0, 1'b0, 0);
      idleCycles("idle_underrun", 2);

      // six bits 1,1,0,1,0,0 with in_vld held high
      applyStimulus("bp6", 16'h000B, 6, 1'b1, 1'b0, 0);
      idleCycles("idle_bp6", 2);

      // bits 1,0,1,1; reset in the low pulse of data symbol 2 (cycle 59)
      applyStimulus("abort", 16'h000D, 4, 1'b1, 1'b0, 59);
      idleCycles("idle_abort", 2);
      applyStimulus("post_reset_01", 16'b10, 2, 1'b1, 1'b0, 0);
      idleCycles("idle_post_reset", 2);

      // back-to-back: second frame transfers in the tx_done cycle
      applyStimulus("b2b_a", 16'b1, 1, 1'b1, 1'b0, 0);
      applyStimulus("b2b_b", 16'b00, 2, 1'b1, 1'b0, 0);
      idleCycles("idle_b2b", 2);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
